// File: rtl/dot_table.sv
// dot_table: processor-written X/Y coordinate table, scanned in slot order and
// streamed out over valid/ready. Build option DOT_TABLE_SKIP_UNSET_EN skips slots not fully written since reset.
module dot_table #(
  parameter int NUM_DOTS = 450,
  parameter int COORD_W  = 10,
  parameter int ID_W     = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dot_wren,
  input  logic               is_yloc,
  input  logic [31:0]        dot_id,
  input  logic [31:0]        dot_loc,
  input  logic               frame_start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [ID_W-1:0]    out_id,
  output logic               scan_busy,
  output logic               scan_done,
  output logic               write_drop
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_DOTS - 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    idx_q, idx_d;
  logic [COORD_W-1:0] out_x_q, out_x_d;
  logic [COORD_W-1:0] out_y_q, out_y_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic               write_drop_q, write_drop_d;
  logic               wr_ok;
  logic [ID_W-1:0]    wr_idx;
  logic               skip_slot;
  logic               unused_loc_bits;

  // Storage is not reset; it relies on build-time zero initialisation of the RAM.
  logic [COORD_W-1:0] x_mem_q [NUM_DOTS];
  logic [COORD_W-1:0] y_mem_q [NUM_DOTS];

  assign wr_ok           = dot_wren && (dot_id < 32'(NUM_DOTS));
  assign wr_idx          = dot_id[ID_W-1:0];
  assign unused_loc_bits = ^dot_loc[31:COORD_W];

  always_ff @(posedge clock) begin
    if (wr_ok) begin
      if (is_yloc) y_mem_q[wr_idx] <= dot_loc[COORD_W-1:0];
      else         x_mem_q[wr_idx] <= dot_loc[COORD_W-1:0];
    end
  end

`ifdef DOT_TABLE_SKIP_UNSET_EN
  logic [NUM_DOTS-1:0] xset_q, xset_d;
  logic [NUM_DOTS-1:0] yset_q, yset_d;

  always_comb begin
    xset_d = xset_q;
    yset_d = yset_q;
    if (wr_ok) begin
      if (is_yloc) yset_d[wr_idx] = 1'b1;
      else         xset_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xset_q <= '0;
      yset_q <= '0;
    end else begin
      xset_q <= xset_d;
      yset_q <= yset_d;
    end
  end

  // Flags are sampled before this cycle's write lands, matching the data read.
  assign skip_slot = !(xset_q[idx_q] && yset_q[idx_q]);
`else
  assign skip_slot = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    out_x_d      = out_x_q;
    out_y_d      = out_y_q;
    out_id_d     = out_id_q;
    write_drop_d = dot_wren && !wr_ok;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        if (skip_slot) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + ID_W'(1);
        end else begin
          out_x_d  = x_mem_q[idx_q];
          out_y_d  = y_mem_q[idx_q];
          out_id_d = idx_q;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ID_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_id_q     <= '0;
      write_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      out_id_q     <= out_id_d;
      write_drop_q <= write_drop_d;
    end
  end

  assign out_valid  = (state_q == PRESENT);
  assign scan_busy  = (state_q != IDLE);
  assign scan_done  = (state_q == DONE);
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_id     = out_id_q;
  assign write_drop = write_drop_q;

endmodule

// File: tb/tb_dot_table.sv
// Bench for dot_table: table-driven write vectors, directed scan corner cases and
// randomized write/scan rounds compared against a slot-array model of the table.
module tb_dot_table;
  localparam int N  = 450;
  localparam int CW = 10;
  localparam int IW = 9;
`ifdef DOT_TABLE_SKIP_UNSET_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          dot_wren = 1'b0, is_yloc = 1'b0, frame_start = 1'b0, out_ready = 1'b0;
  logic [31:0]   dot_id = '0, dot_loc = '0;
  logic          out_valid, scan_busy, scan_done, write_drop;
  logic [CW-1:0] out_x, out_y;
  logic [IW-1:0] out_id;

  dot_table #(.NUM_DOTS(N), .COORD_W(CW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset), .dot_wren(dot_wren), .is_yloc(is_yloc),
    .dot_id(dot_id), .dot_loc(dot_loc), .frame_start(frame_start),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_id(out_id), .scan_busy(scan_busy), .scan_done(scan_done), .write_drop(write_drop)
  );

  always #5 clock = ~clock;

  typedef struct { int id; int x; int y; } beat_t;
  typedef struct { bit isy; logic [31:0] id; logic [31:0] loc; bit drop; } wr_vec_t;

  int total = 0;
  int bad   = 0;
  int mx[N], my[N];
  bit mxs[N], mys[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear_flags();
    for (int i = 0; i < N; i++) begin
      mxs[i] = 1'b0;
      mys[i] = 1'b0;
    end
  endtask

  // Called at posedge+1; asserts reset mid-cycle and checks outputs before any edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_done", scan_done, 0);
    check("rst_drop", write_drop, 0);
    check("rst_x", out_x, 0);
    check("rst_y", out_y, 0);
    check("rst_id", out_id, 0);
    model_clear_flags();
    @(negedge clock);
    #1 reset = 1'b0;
    tick();
  endtask

  task automatic do_write(input bit isy, input logic [31:0] id, input logic [31:0] loc);
    dot_wren = 1'b1; is_yloc = isy; dot_id = id; dot_loc = loc;
    tick();
    dot_wren = 1'b0;
    check("write_drop", write_drop, (id >= N) ? 1 : 0);
    if (id < N) begin
      if (isy) begin my[id] = int'(loc % (1 << CW)); mys[id] = 1'b1; end
      else     begin mx[id] = int'(loc % (1 << CW)); mxs[id] = 1'b1; end
    end
  endtask

  // mode: 0 ready high, 1 random ready, 2 hold first beat for 10 cycles.
  // inject: write X[0]=inj_loc during the first FETCH. reset_at: abort when that id is presented.
  task automatic run_scan(input int mode, input bit inject, input int inj_loc, input int reset_at);
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t b;
    int presented, skipped, stalls, busy, dones, hold, cyc, n;
    bit aborted, have_prev, last_done;
    logic [CW-1:0] px, py;
    logic [IW-1:0] pid;
    stalls = 0; busy = 0; dones = 0; hold = 0; cyc = 0;
    aborted = 0; have_prev = 0; last_done = 0;
    px = '0; py = '0; pid = '0;
    for (int i = 0; i < N; i++)
      if (!SKIP || (mxs[i] && mys[i])) exp_q.push_back('{i, mx[i], my[i]});
    presented = exp_q.size();
    skipped   = N - presented;
    if (inject) begin mx[0] = inj_loc; mxs[0] = 1'b1; end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    if (inject) begin dot_wren = 1'b1; is_yloc = 1'b0; dot_id = 0; dot_loc = inj_loc; end
    while (scan_busy === 1'b1 && cyc < 20000) begin
      cyc++; busy++;
      last_done = scan_done;
      if (scan_done) begin
        dones++;
        check("done_valid", out_valid, 0);
      end
      if (have_prev && out_valid !== 1'b1) check("hold_valid", out_valid, 1);
      if (out_valid) begin
        if (have_prev) begin
          check("hold_x", out_x, px);
          check("hold_y", out_y, py);
          check("hold_id", out_id, pid);
        end
        if (reset_at >= 0 && int'(out_id) == reset_at) begin
          aborted = 1;
          apply_reset();
          break;
        end
        if (mode == 0) out_ready = 1'b1;
        else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        else if (got_q.size() == 0 && hold < 10) begin out_ready = 1'b0; hold++; end
        else out_ready = 1'b1;
        if (out_ready) begin
          b = '{int'(out_id), int'(out_x), int'(out_y)};
          got_q.push_back(b);
          have_prev = 0;
        end else begin
          stalls++; have_prev = 1;
          px = out_x; py = out_y; pid = out_id;
        end
      end else begin
        have_prev = 0;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      tick();
      dot_wren = 1'b0;
    end
    if (!aborted) begin
      check("scan_timeout", (cyc < 20000) ? 1 : 0, 1);
      check("beat_count", got_q.size(), presented);
      n = (got_q.size() < presented) ? got_q.size() : presented;
      for (int i = 0; i < n; i++) begin
        check("beat_id", got_q[i].id, exp_q[i].id);
        check("beat_x", got_q[i].x, exp_q[i].x);
        check("beat_y", got_q[i].y, exp_q[i].y);
      end
      check("done_pulses", dones, 1);
      check("done_last", last_done, 1);
      check("scan_cycles", busy, 2 * presented + skipped + 1 + stalls);
      check("idle_valid", out_valid, 0);
    end
  endtask

  wr_vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 32'd3,          32'd100, 1'b0};
    tbl[1] = '{1'b1, 32'd3,          32'd200, 1'b0};
    tbl[2] = '{1'b0, 32'd450,        32'd55,  1'b1};
    tbl[3] = '{1'b1, 32'd451,        32'd66,  1'b1};
    tbl[4] = '{1'b0, 32'd515,        32'd999, 1'b1};
    tbl[5] = '{1'b1, 32'h1000_0004,  32'd17,  1'b1};
    tbl[6] = '{1'b0, 32'hFFFF_FFFF,  32'd77,  1'b1};
    tbl[7] = '{1'b0, 32'd1000,       32'd1,   1'b1};

    apply_reset();

    for (int i = 0; i < 8; i++) begin
      dot_wren = 1'b1; is_yloc = tbl[i].isy; dot_id = tbl[i].id; dot_loc = tbl[i].loc;
      tick();
      check("tbl_drop", write_drop, tbl[i].drop);
      if (!tbl[i].drop) begin
        if (tbl[i].isy) begin my[tbl[i].id] = int'(tbl[i].loc); mys[tbl[i].id] = 1'b1; end
        else            begin mx[tbl[i].id] = int'(tbl[i].loc); mxs[tbl[i].id] = 1'b1; end
      end
    end
    dot_wren = 1'b0;
    tick();
    check("drop_pulse_end", write_drop, 0);

    run_scan(0, 1'b0, 0, -1);
    run_scan(2, 1'b0, 0, -1);

    apply_reset();
    do_write(1'b0, 32'd5, 32'd7);
    run_scan(0, 1'b0, 0, -1);

    do_write(1'b0, 32'd0, 32'd4);
    do_write(1'b1, 32'd0, 32'd11);
    run_scan(0, 1'b1, 9, -1);
    run_scan(0, 1'b0, 0, -1);

    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_write(1'b0, i, 32'd20 + i);
      do_write(1'b1, i, 32'd40 + i);
    end
    run_scan(0, 1'b0, 0, 2);
    run_scan(0, 1'b0, 0, -1);

    for (int r = 0; r < 4; r++) begin
      if (r == 2) apply_reset();
      for (int k = 0; k < 30; k++) begin
        logic [31:0] id;
        if (k == 29) id = 32'hFFFF_FFF0;
        else if ($urandom_range(0, 1) == 1) id = $urandom_range(0, 19);
        else id = $urandom_range(0, N + 20);
        do_write(1'($urandom_range(0, 1)), id, $urandom);
      end
      run_scan(1, 1'b0, 0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
